// File: rtl/dca_matrix_lsu_local_pkg.sv
// Shared op codes, instruction field positions and FSM encoding
// for the local matrix LSU responder.
package dca_matrix_lsu_local_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_ZERO  = 2'b11
  } op_e;

  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 1;
  localparam int PTR_LSB = 2;
  localparam int PTR_MSB = 9;
  localparam int CNT_LSB = 10;
  localparam int CNT_MSB = 17;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_LOAD   = 3'd2,
    S_STORE  = 3'd3,
    S_ZERO   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/dca_matrix_lsu_local_rowbuf.sv
// Tile row buffer: one write port with zero-fill, async read,
// cleared by the asynchronous reset.
module dca_matrix_lsu_local_rowbuf #(
  parameter int NUM_ROW = 8,
  parameter int BW_ROW  = 128,
  parameter int AW      = 3
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              i_we,
  input  logic              i_zero,
  input  logic [AW-1:0]     i_waddr,
  input  logic [BW_ROW-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [BW_ROW-1:0] o_rdata
);

  logic [BW_ROW-1:0] r_mem [NUM_ROW];

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int i = 0; i < NUM_ROW; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_zero ? '0 : i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dca_matrix_lsu_local.sv
// Local matrix LSU responder: sinst/sload/sstore over one row buffer.
// Define DCA_MATRIX_LSU_LOCAL_ZERO_EN to enable the ZERO op (else NOP).
module dca_matrix_lsu_local
  import dca_matrix_lsu_local_pkg::*;
#(
  parameter int NUM_ROW = 8,
  parameter int BW_ROW  = 128,
  parameter int BW_INST = 32
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               sinst_wvalid,
  input  logic [BW_INST-1:0] sinst_wdata,
  output logic               sinst_wready,
  output logic               sinst_decode_finish,
  output logic               sinst_execute_finish,
  output logic               sinst_busy,
  output logic               sload_tensor_row_wvalid,
  output logic               sload_tensor_row_wlast,
  output logic [BW_ROW-1:0]  sload_tensor_row_wdata,
  input  logic               sload_tensor_row_wready,
  output logic               sstore_tensor_row_rvalid,
  output logic               sstore_tensor_row_rlast,
  input  logic               sstore_tensor_row_rready,
  input  logic [BW_ROW-1:0]  sstore_tensor_row_rdata
);

  localparam int AW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

  state_e          r_state;
  state_e          w_next;
  op_e             r_op;
  logic [AW-1:0]   r_ptr;
  logic [7:0]      r_cnt;
  logic            w_accept;
  logic            w_ld_beat;
  logic            w_st_beat;
  logic            w_zr_beat;
  logic            w_beat;
  logic            w_last;
  logic [BW_ROW-1:0] w_rdata;
  logic            w_unused;

  assign w_unused  = ^sinst_wdata;
  assign w_accept  = (r_state == S_IDLE) & sinst_wvalid;
  assign w_ld_beat = (r_state == S_LOAD) & sload_tensor_row_wready;
  assign w_st_beat = (r_state == S_STORE) & sstore_tensor_row_rready;
  assign w_zr_beat = (r_state == S_ZERO);
  assign w_beat    = w_ld_beat | w_st_beat | w_zr_beat;
  assign w_last    = (r_cnt == 8'd0);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (sinst_wvalid) w_next = S_DECODE;
      S_DECODE: begin
        unique case (r_op)
          OP_LOAD:  w_next = S_LOAD;
          OP_STORE: w_next = S_STORE;
`ifdef DCA_MATRIX_LSU_LOCAL_ZERO_EN
          OP_ZERO:  w_next = S_ZERO;
`else
          OP_ZERO:  w_next = S_DONE;
`endif
          default:  w_next = S_DONE;
        endcase
      end
      S_LOAD:   if (w_ld_beat & w_last) w_next = S_DONE;
      S_STORE:  if (w_st_beat & w_last) w_next = S_DONE;
      S_ZERO:   if (w_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // pointer wraps naturally at AW bits since NUM_ROW is a power of two
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_op  <= OP_NOP;
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= op_e'(sinst_wdata[OP_MSB:OP_LSB]);
      r_ptr <= sinst_wdata[PTR_LSB +: AW];
      r_cnt <= sinst_wdata[CNT_MSB:CNT_LSB];
    end else if (w_beat) begin
      r_ptr <= r_ptr + AW'(1);
      r_cnt <= r_cnt - 8'd1;
    end
  end

  dca_matrix_lsu_local_rowbuf #(
    .NUM_ROW (NUM_ROW),
    .BW_ROW  (BW_ROW),
    .AW      (AW)
  ) u_rowbuf (
    .clk     (clk),
    .rstnn   (rstnn),
    .i_we    (w_st_beat | w_zr_beat),
    .i_zero  (w_zr_beat),
    .i_waddr (r_ptr),
    .i_wdata (sstore_tensor_row_rdata),
    .i_raddr (r_ptr),
    .o_rdata (w_rdata)
  );

  assign sinst_wready             = (r_state == S_IDLE);
  assign sinst_busy               = (r_state != S_IDLE);
  assign sinst_decode_finish      = (r_state == S_DECODE);
  assign sinst_execute_finish     = (r_state == S_DONE);
  assign sload_tensor_row_wvalid  = (r_state == S_LOAD);
  assign sload_tensor_row_wlast   = (r_state == S_LOAD) & w_last;
  assign sload_tensor_row_wdata   = (r_state == S_LOAD) ? w_rdata : '0;
  assign sstore_tensor_row_rvalid = (r_state == S_STORE);
  assign sstore_tensor_row_rlast  = (r_state == S_STORE) & w_last;

endmodule

// File: tb/tb_dca_matrix_lsu_local.sv
// Randomised bench for dca_matrix_lsu_local against a tile-level
// reference model (array of rows, instruction-by-instruction).
module tb_dca_matrix_lsu_local;

  localparam int N  = 8;
  localparam int BW = 128;
`ifdef DCA_MATRIX_LSU_LOCAL_ZERO_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic          clk;
  logic          rstnn;
  logic          sinst_wvalid;
  logic [31:0]   sinst_wdata;
  logic          sinst_wready;
  logic          sinst_decode_finish;
  logic          sinst_execute_finish;
  logic          sinst_busy;
  logic          sload_tensor_row_wvalid;
  logic          sload_tensor_row_wlast;
  logic [BW-1:0] sload_tensor_row_wdata;
  logic          sload_tensor_row_wready;
  logic          sstore_tensor_row_rvalid;
  logic          sstore_tensor_row_rlast;
  logic          sstore_tensor_row_rready;
  logic [BW-1:0] sstore_tensor_row_rdata;

  dca_matrix_lsu_local #(
    .NUM_ROW (N),
    .BW_ROW  (BW),
    .BW_INST (32)
  ) dut (
    .clk                      (clk),
    .rstnn                    (rstnn),
    .sinst_wvalid             (sinst_wvalid),
    .sinst_wdata              (sinst_wdata),
    .sinst_wready             (sinst_wready),
    .sinst_decode_finish      (sinst_decode_finish),
    .sinst_execute_finish     (sinst_execute_finish),
    .sinst_busy               (sinst_busy),
    .sload_tensor_row_wvalid  (sload_tensor_row_wvalid),
    .sload_tensor_row_wlast   (sload_tensor_row_wlast),
    .sload_tensor_row_wdata   (sload_tensor_row_wdata),
    .sload_tensor_row_wready  (sload_tensor_row_wready),
    .sstore_tensor_row_rvalid (sstore_tensor_row_rvalid),
    .sstore_tensor_row_rlast  (sstore_tensor_row_rlast),
    .sstore_tensor_row_rready (sstore_tensor_row_rready),
    .sstore_tensor_row_rdata  (sstore_tensor_row_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  logic [BW-1:0] mem [N];

  task automatic chk(input string tag, input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, BW'(sinst_busy), '0);
    chk({tag, "_wready"}, BW'(sinst_wready), BW'(1));
    chk({tag, "_dec"}, BW'(sinst_decode_finish), '0);
    chk({tag, "_exe"}, BW'(sinst_execute_finish), '0);
    chk({tag, "_ldv"}, BW'(sload_tensor_row_wvalid), '0);
    chk({tag, "_ldl"}, BW'(sload_tensor_row_wlast), '0);
    chk({tag, "_ldd"}, sload_tensor_row_wdata, '0);
    chk({tag, "_stv"}, BW'(sstore_tensor_row_rvalid), '0);
    chk({tag, "_stl"}, BW'(sstore_tensor_row_rlast), '0);
  endtask

  // mode: 0 ready always, 1 ready toggles, 2 ready random
  // base 0 means random store data, otherwise base + inc*beat
  task automatic run_inst(input int op, input int st, input int cm1,
                          input int mode, input bit hold,
                          input logic [BW-1:0] base, input int inc);
    logic [31:0] rnd;
    logic [31:0] instr;
    logic [7:0]  st8;
    logic [7:0]  cm8;
    logic [1:0]  op2;
    logic [BW-1:0] d;
    int eop;
    int idx;
    int cyc;
    bit rdy;
    rnd = $urandom;
    st8 = st[7:0];
    cm8 = cm1[7:0];
    op2 = op[1:0];
    instr = {rnd[31:18], cm8, st8, op2};
    eop = (op == 3 && !ZEN) ? 0 : op;
    @(negedge clk);
    sinst_wvalid = 1'b1;
    sinst_wdata  = instr;
    #1;
    chk("acc_wready", BW'(sinst_wready), BW'(1));
    chk("acc_busy", BW'(sinst_busy), '0);
    @(negedge clk);
    sinst_wvalid = hold;
    sinst_wdata  = $urandom;
    #1;
    chk("dec_pulse", BW'(sinst_decode_finish), BW'(1));
    chk("dec_busy", BW'(sinst_busy), BW'(1));
    chk("dec_wready", BW'(sinst_wready), '0);
    chk("dec_ldv", BW'(sload_tensor_row_wvalid), '0);
    chk("dec_stv", BW'(sstore_tensor_row_rvalid), '0);
    if (eop == 1 || eop == 2) begin
      idx = 0;
      cyc = 0;
      while (idx <= cm1 && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2) == 1;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        d = (base == '0) ? rnd_row() : base + BW'(inc * idx);
        sstore_tensor_row_rdata = d;
        sload_tensor_row_wready  = (eop == 1) ? rdy : 1'b0;
        sstore_tensor_row_rready = (eop == 2) ? rdy : 1'b0;
        #1;
        if (eop == 1) begin
          chk("ld_valid", BW'(sload_tensor_row_wvalid), BW'(1));
          chk("ld_data", sload_tensor_row_wdata, mem[(st + idx) % N]);
          chk("ld_last", BW'(sload_tensor_row_wlast), BW'(idx == cm1));
          chk("ld_stv", BW'(sstore_tensor_row_rvalid), '0);
        end else begin
          chk("st_valid", BW'(sstore_tensor_row_rvalid), BW'(1));
          chk("st_last", BW'(sstore_tensor_row_rlast), BW'(idx == cm1));
          chk("st_ldv", BW'(sload_tensor_row_wvalid), '0);
        end
        chk("beat_busy", BW'(sinst_busy), BW'(1));
        chk("beat_exe", BW'(sinst_execute_finish), '0);
        if (rdy) begin
          if (eop == 2) mem[(st + idx) % N] = d;
          idx++;
        end
      end
      if (idx <= cm1) chk("beat_timeout", BW'(idx), BW'(cm1 + 1));
    end else if (eop == 3) begin
      for (int i = 0; i <= cm1; i++) begin
        @(negedge clk);
        #1;
        chk("zr_ldv", BW'(sload_tensor_row_wvalid), '0);
        chk("zr_stv", BW'(sstore_tensor_row_rvalid), '0);
        chk("zr_busy", BW'(sinst_busy), BW'(1));
        mem[(st + i) % N] = '0;
      end
    end
    @(negedge clk);
    sinst_wvalid = 1'b0;
    sload_tensor_row_wready  = 1'b0;
    sstore_tensor_row_rready = 1'b0;
    #1;
    chk("done_exe", BW'(sinst_execute_finish), BW'(1));
    chk("done_busy", BW'(sinst_busy), BW'(1));
    chk("done_dec", BW'(sinst_decode_finish), '0);
    chk("done_ldv", BW'(sload_tensor_row_wvalid), '0);
    chk("done_stv", BW'(sstore_tensor_row_rvalid), '0);
    @(negedge clk);
    #1;
    idle_chk("post");
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    sinst_wvalid = 1'b1;
    sinst_wdata  = {14'd0, 8'd3, 8'd0, 2'b01};
    @(negedge clk);
    sinst_wvalid = 1'b0;
    @(negedge clk);
    sload_tensor_row_wready = 1'b1;
    @(negedge clk);
    sload_tensor_row_wready = 1'b0;
    #1;
    chk("rst_pre_ldv", BW'(sload_tensor_row_wvalid), BW'(1));
    chk("rst_pre_ldd", sload_tensor_row_wdata, mem[1]);
    #2;
    rstnn = 1'b0;
    #1;
    idle_chk("rst_async");
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_hold_exe", BW'(sinst_execute_finish), '0);
    end
    rstnn = 1'b1;
    run_inst(1, 0, N - 1, 0, 1'b0, '0, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rstnn  = 1'b0;
    sinst_wvalid = 1'b0;
    sinst_wdata  = '0;
    sload_tensor_row_wready  = 1'b0;
    sstore_tensor_row_rready = 1'b0;
    sstore_tensor_row_rdata  = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    #1;
    idle_chk("reset");
    repeat (2) @(negedge clk);
    rstnn = 1'b1;

    run_inst(2, 0, 3, 0, 1'b0, BW'('hA0), 1);
    run_inst(1, 0, 3, 1, 1'b0, '0, 0);
    run_inst(2, 6, 3, 0, 1'b0, BW'('hB0), 1);
    run_inst(1, 6, 3, 0, 1'b0, '0, 0);
    run_inst(1, 0, 1, 2, 1'b0, '0, 0);
    run_inst(0, 5, 9, 0, 1'b1, '0, 0);
    run_inst(1, 0, N - 1, 0, 1'b0, '0, 0);
    run_inst(2, 0, N - 1, 0, 1'b0, BW'('hFF), 0);
    run_inst(3, 2, 1, 0, 1'b1, '0, 0);
    run_inst(1, 0, N - 1, 2, 1'b0, '0, 0);
    run_inst(2, 250, 20, 2, 1'b1, '0, 0);
    run_inst(1, 3, 17, 2, 1'b1, '0, 0);

    for (int k = 0; k < 60; k++) begin
      run_inst($urandom_range(0, 3), $urandom_range(0, 255),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40)
                                           : $urandom_range(0, 9),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), '0, 0);
    end

    reset_mid_load();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
